cam_capture_writer: RTL

Write-side front end of the frame buffer. Samples the OV7670 parallel bus (VSYNC, HREF, 8-bit data) in the camera pixel-clock domain and packs each two-byte RGB565 pixel into 9-bit RGB333. It issues one BRAM write per pixel at linear address `row*H_PIX + col`, so the display-side reader can scan the same buffer from address 0 to H_PIX*V_LINES−1. The writer discards the first SKIP_FRAMES frames while the sensor registers settle.

---
 rtl/cam_pkg.sv | 29 ++
 rtl/cam_capture_writer_if.sv | 27 ++
 rtl/sync_edge_det.sv | 36 +++
 rtl/cam_capture_writer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types, widths and the colour packing helper for the camera capture path.
package cam_pkg;

  typedef enum logic [1:0] {
    SKIP    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  localparam int unsigned RGB333_W = 9;
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned COL_W    = 10;
  localparam int unsigned ROW_W    = 9;
  localparam int unsigned SKIP_W   = 4;
  localparam int unsigned BYTE_W   = 8;

  // One BRAM write: linear pixel address plus packed colour.
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [RGB333_W-1:0] data;
  } pix_wr_t;

  // Packs the two sensor bytes of a pixel into {R[2:0], G[2:0], B[2:0]}.
  function automatic logic [RGB333_W-1:0] rgb565_to_333(input logic [BYTE_W-1:0] b0,
                                                        input logic [BYTE_W-1:0] b1);
    return {b0[7:5], b0[2:0], b1[4:2]};
  endfunction

endpackage

// File: rtl/cam_capture_writer_if.sv
// Camera parallel bus in, frame-buffer write port and status out.
interface cam_capture_writer_if;
  import cam_pkg::*;

  logic                i_cam_vsync;
  logic                i_cam_href;
  logic [BYTE_W-1:0]   i_cam_data;
  logic                i_cap_en;
  logic                o_pix_wr;
  logic [ADDR_W-1:0]   o_pix_addr;
  logic [RGB333_W-1:0] o_pix_data;
  logic                o_frame_done;
  logic                o_capturing;

  // Sensor / environment side.
  modport master (
    output i_cam_vsync, i_cam_href, i_cam_data, i_cap_en,
    input  o_pix_wr, o_pix_addr, o_pix_data, o_frame_done, o_capturing
  );

  // Capture writer side.
  modport slave (
    input  i_cam_vsync, i_cam_href, i_cam_data, i_cap_en,
    output o_pix_wr, o_pix_addr, o_pix_data, o_frame_done, o_capturing
  );

endinterface

// File: rtl/sync_edge_det.sv
// Registers vsync/href once and flags their edges against the previous registered copy.
module sync_edge_det (
  input  logic i_pclk,
  input  logic i_rst_pclk,
  input  logic i_vsync,
  input  logic i_href,
  output logic r_hr,
  output logic vs_rise_c,
  output logic vs_fall_c,
  output logic hr_fall_c
);

  logic r_vs;
  logic r_vs_q;
  logic r_hr_q;

  // Input register plus one-cycle history for edge detection.
  always_ff @(posedge i_pclk) begin
    if (i_rst_pclk) begin
      r_vs   <= 1'b0;
      r_vs_q <= 1'b0;
      r_hr   <= 1'b0;
      r_hr_q <= 1'b0;
    end else begin
      r_vs   <= i_vsync;
      r_vs_q <= r_vs;
      r_hr   <= i_href;
      r_hr_q <= r_hr;
    end
  end

  assign vs_rise_c = r_vs & ~r_vs_q;
  assign vs_fall_c = ~r_vs & r_vs_q;
  assign hr_fall_c = ~r_hr & r_hr_q;

endmodule

// File: rtl/cam_capture_writer.sv
// OV7670 capture: skips settling frames, pairs bytes into RGB333 pixels, writes them row-major.
module cam_capture_writer
  import cam_pkg::*;
#(
  parameter int unsigned H_PIX       = 640,
  parameter int unsigned V_LINES     = 480,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic                 i_pclk,
  input  logic                 i_rst_pclk,
  cam_capture_writer_if.slave  bus
);

  logic              r_hr;
  logic              vs_rise_c;
  logic              vs_fall_c;
  logic              hr_fall_c;
  logic [BYTE_W-1:0] r_d;
  logic [BYTE_W-1:0] r_b0;
  logic              phase;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic [SKIP_W-1:0] skip_cnt;
  logic              wrote_any;
  cap_state_t        state;
  cap_state_t        state_d;
  logic              pix_wr_q;
  pix_wr_t           pix_q;
  logic              frame_done_q;
  logic              capturing_q;
  logic              skip_inc_c;
  logic              frame_start_c;
  logic              frame_end_c;
  logic              byte_c;
  logic              line_end_c;
  logic              in_win_c;

  sync_edge_det u_sync (
    .i_pclk     (i_pclk),
    .i_rst_pclk (i_rst_pclk),
    .i_vsync    (bus.i_cam_vsync),
    .i_href     (bus.i_cam_href),
    .r_hr       (r_hr),
    .vs_rise_c  (vs_rise_c),
    .vs_fall_c  (vs_fall_c),
    .hr_fall_c  (hr_fall_c)
  );

  // State register.
  always_ff @(posedge i_pclk) begin
    if (i_rst_pclk) state <= SKIP;
    else            state <= state_d;
  end

  // Next state and per-cycle datapath strobes; a vsync rise beats any byte in the same cycle.
  always_comb begin
    state_d       = state;
    skip_inc_c    = 1'b0;
    frame_start_c = 1'b0;
    frame_end_c   = 1'b0;
    byte_c        = 1'b0;
    line_end_c    = 1'b0;
    case (state)
      SKIP: begin
        if (vs_rise_c) begin
          skip_inc_c = 1'b1;
          if (skip_cnt == SKIP_W'(SKIP_FRAMES - 1)) state_d = ARM;
        end
      end
      ARM: begin
        if (vs_fall_c && bus.i_cap_en) begin
          state_d       = CAPTURE;
          frame_start_c = 1'b1;
        end
      end
      CAPTURE: begin
        if (vs_rise_c) begin
          state_d     = ARM;
          frame_end_c = 1'b1;
        end else if (r_hr) begin
          byte_c = 1'b1;
        end else if (hr_fall_c) begin
          line_end_c = 1'b1;
        end
      end
      default: state_d = SKIP;
    endcase
    in_win_c = (col < COL_W'(H_PIX)) && (row < ROW_W'(V_LINES));
  end

  // Byte pairing, row/col/address counters and registered outputs.
  always_ff @(posedge i_pclk) begin
    if (i_rst_pclk) begin
      r_d          <= '0;
      r_b0         <= '0;
      phase        <= 1'b0;
      col          <= '0;
      row          <= '0;
      addr         <= '0;
      skip_cnt     <= '0;
      wrote_any    <= 1'b0;
      pix_wr_q     <= 1'b0;
      pix_q        <= '0;
      frame_done_q <= 1'b0;
      capturing_q  <= 1'b0;
    end else begin
      r_d          <= bus.i_cam_data;
      pix_wr_q     <= 1'b0;
      frame_done_q <= frame_end_c && wrote_any;
      capturing_q  <= (state_d == CAPTURE);
      if (skip_inc_c) skip_cnt <= skip_cnt + SKIP_W'(1);
      if (frame_start_c) begin
        phase     <= 1'b0;
        col       <= '0;
        row       <= '0;
        addr      <= '0;
        wrote_any <= 1'b0;
      end
      if (byte_c) begin
        phase <= ~phase;
        if (!phase) begin
          r_b0 <= r_d;
        end else begin
          if (col != '1) col <= col + COL_W'(1);
          if (in_win_c) begin
            pix_wr_q   <= 1'b1;
            pix_q.addr <= addr;
            pix_q.data <= rgb565_to_333(r_b0, r_d);
            addr       <= addr + ADDR_W'(1);
            wrote_any  <= 1'b1;
          end
        end
      end
      // Line end pads short lines so the next row starts at row*H_PIX.
      if (line_end_c) begin
        phase <= 1'b0;
        col   <= '0;
        if (row != '1) row <= row + ROW_W'(1);
        if (in_win_c) addr <= addr + ADDR_W'(H_PIX) - ADDR_W'(col);
      end
    end
  end

  assign bus.o_pix_wr     = pix_wr_q;
  assign bus.o_pix_addr   = pix_q.addr;
  assign bus.o_pix_data   = pix_q.data;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_capturing  = capturing_q;

endmodule
